modstick_bus_arb: RTL
=====================

# modstick_bus_arb

Two-master round-robin arbiter for the modstick 16-bit register bus (valid/iswrite/addr/wdata/rdata/ack). It places the Modbus endpoint (master 0) and a local debug master (master 1) in front of the single register-bank slave. It issues one single-cycle `s_valid` transaction at a time and returns read data to the winning master. A bounded ack timeout converts a hung or unmapped slave into an error response.

## Interface
- `TIMEOUT`, 15: max cycles to wait for `s_ack` after `s_valid`; legal range 1..255.
- `ERR_DATA`, 16'hdead: value returned on `mX_rdata` on timeout.

- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `m0_req`, `m1_req`  in  1  master request; held with fields stable until the matching `mX_ack`
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read
- `m0_addr`, `m1_addr`  in  16  register address
- `m0_wdata`, `m1_wdata`  in  16  write data
- `m0_rdata`, `m1_rdata`  out  16  read data; valid while `mX_ack` = 1
- `m0_ack`, `m1_ack`  out  1  one-cycle completion strobe
- `m0_err`, `m1_err`  out  1  qualifies `mX_ack`; 1 = timeout
- `s_valid`  out  1  one-cycle transaction strobe to the slave
- `s_iswrite`  out  1  to slave
- `s_addr`  out  16  to slave
- `s_wdata`  out  16  to slave
- `s_rdata`  in  16  from slave
- `s_ack`  in  1  from slave
- `busy`  out  1  1 in any state other than IDLE
- `to_count`  out  8  saturating count of timeouts since reset

## Operation
- States: IDLE, WAIT, RESP. All outputs are registered.
- IDLE
  - If no `mX_req` is asserted, stay in IDLE.
  - If exactly one `mX_req` is asserted, grant that master.
  - If both are asserted, grant the master that is not `last`.
  - On grant: latch the master's we/addr/wdata into `s_*`, set `s_valid` = 1, clear the timeout counter, and go to WAIT.
- WAIT
  - `s_valid` is high only in the first WAIT cycle.
  - `s_iswrite`, `s_addr` and `s_wdata` hold stable through the whole of WAIT.
  - `s_ack` is accepted only in WAIT cycles after the `s_valid` cycle.
  - On `s_ack`: capture `s_rdata` and go to RESP with err = 0.
  - Otherwise the counter increments. When it reaches `TIMEOUT`, go to RESP with err = 1, data = `ERR_DATA`, and `to_count` += 1, saturating at 255.
  - If `s_ack` arrives in the same cycle the counter reaches `TIMEOUT`, the ack wins and no error is reported.
- RESP
  - Drive the granted master's `mX_ack` = 1 for exactly one cycle, with its `mX_rdata` and `mX_err`.
  - For writes, `mX_rdata` = captured `s_rdata` (don't-care to master).
  - The non-granted master's ack, err and rdata stay 0.
  - Set `last` = granted master. Go to IDLE.
  - No arbitration happens in RESP, so a req still high during the ack cycle is not sampled until IDLE.
- `s_ack` in IDLE or RESP (late or stray ack) is ignored and has no effect on any output.
- `mX_rdata` and `mX_err` hold their value until that master's next RESP.
- Reset (any state, including mid-transaction):
  - State goes to IDLE and `last` = 1, so master 0 wins the first tie.
  - Every output goes to 0, including `to_count`.
  - An aborted transaction produces no ack.
  - Requests still pending when reset deasserts are re-arbitrated from IDLE.

## Timing
- Slave that acks one cycle after valid (the modstick register bank):
  - cycle N: IDLE sees req
  - N+1: `s_valid`
  - N+2: `s_ack`
  - N+3: `mX_ack`
  - N+4: IDLE
- Request-to-ack latency is 3 cycles. Sustained throughput is one transaction per 4 cycles.
- Timeout path: `mX_ack` with err = 1 in cycle N+2+`TIMEOUT`.
- Master may change req and fields on the clock edge that ends its ack cycle. The earliest re-sample is the next IDLE cycle.
- With both masters continuously requesting, grants alternate 0,1,0,1…; neither master waits more than one transaction.

## Test plan
- Reset, then m0 read of addr 0 with a slave model acking at +1 returning 16'h1234 → `s_valid` at N+1 only; `m0_ack` = 1 at N+3 with `m0_rdata` = 16'h1234 and `m0_err` = 0; `m1_ack` stays 0.
- m0 and m1 request simultaneously from reset, writing 16'h0011 to addr 3 and 16'h0022 to addr 3 respectively, then hold requests → m0 is served first and then m1; the slave sees 16'h0011 then 16'h0022; grants alternate over 6 transactions with a 4-cycle spacing.
- Slave never acks, `TIMEOUT` = 15 → `m1_ack` with `m1_err` = 1 and `m1_rdata` = 16'hdead at N+17; `to_count` = 1; an injected `s_ack` at N+18 causes no ack to either master.
- Slave acks in exactly the cycle the counter reaches `TIMEOUT` → err = 0, data = `s_rdata`, `to_count` unchanged; 300 forced timeouts → `to_count` saturates at 8'hff.
- Assert reset in the WAIT cycle following `s_valid` with m0 still requesting → all outputs 0 the next cycle and no `m0_ack`; after reset deasserts, m0's request is reissued with `s_valid` one cycle after the first IDLE cycle.
- Stray `s_ack` pulses in IDLE while no request is pending → no `mX_ack`, `busy` = 0, `s_valid` = 0.

Source files
------------

// File: rtl/modstick_bus_arb.sv
// Two-master round-robin arbiter for the modstick 16-bit register bus.
// Master 0 (Modbus endpoint) and master 1 (debug) share one register-bank slave.
// One transaction is in flight at a time. A bounded ack wait turns a silent slave
// into an error response carrying ERR_DATA.
module modstick_bus_arb #(
    parameter int unsigned TIMEOUT  = 15,
    parameter logic [15:0] ERR_DATA = 16'hdead
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [15:0] m0_addr,
    input  logic [15:0] m0_wdata,
    output logic [15:0] m0_rdata,
    output logic        m0_ack,
    output logic        m0_err,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [15:0] m1_addr,
    input  logic [15:0] m1_wdata,
    output logic [15:0] m1_rdata,
    output logic        m1_ack,
    output logic        m1_err,

    output logic        s_valid,
    output logic        s_iswrite,
    output logic [15:0] s_addr,
    output logic [15:0] s_wdata,
    input  logic [15:0] s_rdata,
    input  logic        s_ack,

    output logic        busy,
    output logic [7:0]  to_count
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    // Wait-counter value in the last WAIT cycle that may still accept an ack.
    // The counter only advances after the s_valid cycle.
    localparam logic [7:0] ToLast = 8'(TIMEOUT - 1);

    state_e      r_state, w_state_d;
    logic        r_gnt, w_gnt_d;
    logic        r_last, w_last_d;
    logic [7:0]  r_cnt, w_cnt_d;
    logic        r_busy, w_busy_d;
    logic [7:0]  r_to_count, w_to_count_d;

    logic        r_s_valid, w_s_valid_d;
    logic        r_s_iswrite, w_s_iswrite_d;
    logic [15:0] r_s_addr, w_s_addr_d;
    logic [15:0] r_s_wdata, w_s_wdata_d;

    logic        r_m0_ack, w_m0_ack_d;
    logic        r_m0_err, w_m0_err_d;
    logic [15:0] r_m0_rdata, w_m0_rdata_d;
    logic        r_m1_ack, w_m1_ack_d;
    logic        r_m1_err, w_m1_err_d;
    logic [15:0] r_m1_rdata, w_m1_rdata_d;

    // Winner in IDLE: the sole requester, or on a tie the master that did not go last.
    logic        w_pick;
    // Completion of the wait phase this cycle, with its response payload.
    logic        w_done;
    logic        w_done_err;
    logic [15:0] w_done_data;

    assign w_pick = (m0_req && m1_req) ? ~r_last : m1_req;

    assign m0_ack    = r_m0_ack;
    assign m0_err    = r_m0_err;
    assign m0_rdata  = r_m0_rdata;
    assign m1_ack    = r_m1_ack;
    assign m1_err    = r_m1_err;
    assign m1_rdata  = r_m1_rdata;
    assign s_valid   = r_s_valid;
    assign s_iswrite = r_s_iswrite;
    assign s_addr    = r_s_addr;
    assign s_wdata   = r_s_wdata;
    assign busy      = r_busy;
    assign to_count  = r_to_count;

    // State and output registers; synchronous reset clears everything, last = 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_gnt       <= 1'b0;
            r_last      <= 1'b1;
            r_cnt       <= 8'd0;
            r_busy      <= 1'b0;
            r_to_count  <= 8'd0;
            r_s_valid   <= 1'b0;
            r_s_iswrite <= 1'b0;
            r_s_addr    <= 16'd0;
            r_s_wdata   <= 16'd0;
            r_m0_ack    <= 1'b0;
            r_m0_err    <= 1'b0;
            r_m0_rdata  <= 16'd0;
            r_m1_ack    <= 1'b0;
            r_m1_err    <= 1'b0;
            r_m1_rdata  <= 16'd0;
        end else begin
            r_state     <= w_state_d;
            r_gnt       <= w_gnt_d;
            r_last      <= w_last_d;
            r_cnt       <= w_cnt_d;
            r_busy      <= w_busy_d;
            r_to_count  <= w_to_count_d;
            r_s_valid   <= w_s_valid_d;
            r_s_iswrite <= w_s_iswrite_d;
            r_s_addr    <= w_s_addr_d;
            r_s_wdata   <= w_s_wdata_d;
            r_m0_ack    <= w_m0_ack_d;
            r_m0_err    <= w_m0_err_d;
            r_m0_rdata  <= w_m0_rdata_d;
            r_m1_ack    <= w_m1_ack_d;
            r_m1_err    <= w_m1_err_d;
            r_m1_rdata  <= w_m1_rdata_d;
        end
    end

    // Next-state and next-output logic for the IDLE/WAIT/RESP sequence.
    always_comb begin
        w_state_d     = r_state;
        w_gnt_d       = r_gnt;
        w_last_d      = r_last;
        w_cnt_d       = r_cnt;
        w_to_count_d  = r_to_count;
        w_s_valid_d   = 1'b0;
        w_s_iswrite_d = r_s_iswrite;
        w_s_addr_d    = r_s_addr;
        w_s_wdata_d   = r_s_wdata;
        w_m0_ack_d    = 1'b0;
        w_m0_err_d    = r_m0_err;
        w_m0_rdata_d  = r_m0_rdata;
        w_m1_ack_d    = 1'b0;
        w_m1_err_d    = r_m1_err;
        w_m1_rdata_d  = r_m1_rdata;
        w_done        = 1'b0;
        w_done_err    = 1'b0;
        w_done_data   = 16'd0;

        unique case (r_state)
            StIdle: begin
                if (m0_req || m1_req) begin
                    w_gnt_d     = w_pick;
                    w_state_d   = StWait;
                    w_s_valid_d = 1'b1;
                    w_cnt_d     = 8'd0;
                    if (w_pick) begin
                        w_s_iswrite_d = m1_we;
                        w_s_addr_d    = m1_addr;
                        w_s_wdata_d   = m1_wdata;
                    end else begin
                        w_s_iswrite_d = m0_we;
                        w_s_addr_d    = m0_addr;
                        w_s_wdata_d   = m0_wdata;
                    end
                end
            end
            StWait: begin
                // An ack coincident with s_valid is too early and is ignored.
                if (!r_s_valid) begin
                    if (s_ack) begin
                        w_done      = 1'b1;
                        w_done_data = s_rdata;
                    end else if (r_cnt == ToLast) begin
                        w_done      = 1'b1;
                        w_done_err  = 1'b1;
                        w_done_data = ERR_DATA;
                        if (r_to_count != 8'hff) begin
                            w_to_count_d = r_to_count + 8'd1;
                        end
                    end else begin
                        w_cnt_d = r_cnt + 8'd1;
                    end
                end
            end
            StResp: begin
                w_last_d  = r_gnt;
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        if (w_done) begin
            w_state_d = StResp;
            if (r_gnt) begin
                w_m1_ack_d   = 1'b1;
                w_m1_err_d   = w_done_err;
                w_m1_rdata_d = w_done_data;
            end else begin
                w_m0_ack_d   = 1'b1;
                w_m0_err_d   = w_done_err;
                w_m0_rdata_d = w_done_data;
            end
        end

        w_busy_d = (w_state_d != StIdle);
    end

endmodule
